life_ctrl: RTL and testbench

LIFE_CTRL -- requirements
Module: life_ctrl

---
 rtl/life_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_life_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_ctrl.sv
// Sequencing controller for an 8x8 Game of Life grid: seeds the grid from a
// Galois LFSR, paces generation steps and halts on extinction or still life.
module life_ctrl #(
    parameter logic [63:0] SEED_INIT = 64'h0123_4567_89AB_CDEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        randomize,
    input  logic        pause,
    input  logic [3:0]  rate,
    input  logic [63:0] grid_in,
    output logic [63:0] seed,
    output logic        muxseed,
    output logic        load,
    output logic [15:0] gen_count,
    output logic [1:0]  state,
    output logic [1:0]  halt_cause
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEED = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    // Right-shift Galois form of x^64+x^63+x^61+x^60+1.
    localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_EXTINCT = 2'b01;
    localparam logic [1:0] CAUSE_STILL   = 2'b10;

    function automatic logic [63:0] lfsr_next(input logic [63:0] cur);
        lfsr_next = {1'b0, cur[63:1]} ^ (cur[0] ? LFSR_TAPS : 64'h0);
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic [63:0] lfsr_r;
    logic [15:0] gen_count_r;
    logic [1:0]  halt_cause_r;
    logic [3:0]  tick_cnt_r;
    logic        prev_valid_r;
    logic [63:0] prev_grid_r;

    logic        tick_s;
    logic [1:0]  cause_s;
    logic        step_s;
    logic        run_entry_s;
    logic        load_s;
    logic        muxseed_s;

    // Tick detection and halt-condition classification for the current cycle.
    always_comb begin
        tick_s  = 1'b0;
        cause_s = CAUSE_NONE;
        step_s  = 1'b0;
        if ((state_r == ST_RUN) && !pause && (tick_cnt_r == rate)) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
        // Extinction wins over still life when the grid is empty twice.
        if (tick_s && (grid_in == 64'h0)) begin
            cause_s = CAUSE_EXTINCT;
        end else if (tick_s && prev_valid_r && (grid_in == prev_grid_r)) begin
            cause_s = CAUSE_STILL;
        end else begin
            cause_s = CAUSE_NONE;
        end
        step_s = tick_s && (cause_s == CAUSE_NONE);
    end

    // Grid-register write enable and mux select, forced low while in reset.
    always_comb begin
        load_s    = 1'b0;
        muxseed_s = 1'b0;
        if (reset) begin
            load_s    = 1'b0;
            muxseed_s = 1'b0;
        end else begin
            case (state_r)
                ST_SEED: begin
                    load_s    = 1'b1;
                    muxseed_s = 1'b1;
                end
                ST_RUN: begin
                    load_s    = step_s;
                    muxseed_s = 1'b0;
                end
                default: begin
                    load_s    = 1'b0;
                    muxseed_s = 1'b0;
                end
            endcase
        end
    end

    // Next-state selection; randomize overrides every other request.
    always_comb begin
        state_nxt_s = state_r;
        if (randomize) begin
            state_nxt_s = ST_SEED;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) state_nxt_s = ST_RUN;
                    else       state_nxt_s = ST_IDLE;
                end
                ST_SEED: begin
                    state_nxt_s = ST_IDLE;
                end
                ST_RUN: begin
                    if (cause_s != CAUSE_NONE) state_nxt_s = ST_HALT;
                    else                       state_nxt_s = ST_RUN;
                end
                ST_HALT: begin
                    if (start) state_nxt_s = ST_RUN;
                    else       state_nxt_s = ST_HALT;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
        run_entry_s = (state_nxt_s == ST_RUN) && (state_r != ST_RUN);
    end

    // State register and LFSR; the LFSR only moves while the grid is seeding.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            lfsr_r  <= SEED_INIT;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == ST_SEED) begin
                lfsr_r <= lfsr_next(lfsr_r);
            end else begin
                lfsr_r <= lfsr_r;
            end
        end
    end

    // Step pacing: tick counter, generation count and halt reason.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_r   <= 4'd0;
            gen_count_r  <= 16'd0;
            halt_cause_r <= CAUSE_NONE;
        end else if (run_entry_s) begin
            tick_cnt_r   <= 4'd0;
            gen_count_r  <= 16'd0;
            halt_cause_r <= CAUSE_NONE;
        end else begin
            // A counter already past rate wraps through 15 before matching.
            if ((state_r == ST_RUN) && !pause) begin
                tick_cnt_r <= tick_s ? 4'd0 : (tick_cnt_r + 4'd1);
            end else begin
                tick_cnt_r <= tick_cnt_r;
            end
            if (step_s && (gen_count_r != 16'hFFFF)) begin
                gen_count_r <= gen_count_r + 16'd1;
            end else begin
                gen_count_r <= gen_count_r;
            end
            if ((state_r == ST_RUN) && (state_nxt_s == ST_HALT)) begin
                halt_cause_r <= cause_s;
            end else begin
                halt_cause_r <= halt_cause_r;
            end
        end
    end

    // Previous-generation snapshot used for still-life detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_valid_r <= 1'b0;
            prev_grid_r  <= 64'h0;
        end else if (run_entry_s) begin
            prev_valid_r <= 1'b0;
            prev_grid_r  <= prev_grid_r;
        end else if (step_s) begin
            prev_valid_r <= 1'b1;
            prev_grid_r  <= grid_in;
        end else begin
            prev_valid_r <= prev_valid_r;
            prev_grid_r  <= prev_grid_r;
        end
    end

    assign seed       = lfsr_r;
    assign state      = state_r;
    assign gen_count  = gen_count_r;
    assign halt_cause = halt_cause_r;
    assign load       = load_s;
    assign muxseed    = muxseed_s;

endmodule

// File: tb/tb_life_ctrl.sv
// Self-checking bench for life_ctrl: directed scenarios plus random stimulus,
// every cycle compared against a cycle-level behavioural reference.
module tb_life_ctrl;

    localparam logic [63:0] INIT  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;
    localparam logic [63:0] BLOCK   = 64'h0000_0000_0018_1800;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        randomize = 1'b0;
    logic        pause = 1'b0;
    logic [3:0]  rate = 4'd0;
    logic [63:0] grid_in = 64'h0;
    logic [63:0] seed;
    logic        muxseed;
    logic        load;
    logic [15:0] gen_count;
    logic [1:0]  state;
    logic [1:0]  halt_cause;

    int errs = 0;
    int checks = 0;

    // reference model: 0 idle, 1 seeding, 2 running, 3 halted
    int          m_state;
    logic [63:0] m_seed;
    int          m_gen;
    int          m_cause;
    int          m_cnt;
    bit          m_pv;
    logic [63:0] m_prev;

    life_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .randomize(randomize),
        .pause(pause), .rate(rate), .grid_in(grid_in), .seed(seed),
        .muxseed(muxseed), .load(load), .gen_count(gen_count),
        .state(state), .halt_cause(halt_cause)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_lfsr(input logic [63:0] v);
        logic [63:0] poly;
        int taps[4];
        taps = '{64, 63, 61, 60};
        poly = 64'h0;
        foreach (taps[i]) poly[taps[i]-1] = 1'b1;
        return v[0] ? ((v >> 1) ^ poly) : (v >> 1);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_seed = INIT; m_gen = 0; m_cause = 0;
        m_cnt = 0; m_pv = 1'b0; m_prev = 64'h0;
    endtask

    // why: 0 no halt, 1 extinct, 2 still life
    task automatic model_eval(output bit tick, output int why);
        tick = (m_state == 2) && !pause && (m_cnt == int'(rate));
        why = 0;
        if (tick) begin
            if (grid_in == 64'h0) why = 1;
            else if (m_pv && grid_in == m_prev) why = 2;
        end
    endtask

    task automatic model_update();
        bit tick;
        int why;
        int nxt;
        int old;
        model_eval(tick, why);
        if (reset) begin
            model_reset();
        end else begin
            old = m_state;
            if (old == 1) m_seed = ref_lfsr(m_seed);
            if (tick && why == 0) begin
                m_prev = grid_in;
                m_pv = 1'b1;
                if (m_gen < 65535) m_gen++;
            end
            if (old == 2 && !pause) m_cnt = tick ? 0 : (m_cnt + 1) % 16;
            if (randomize) nxt = 1;
            else if (old == 1) nxt = 0;
            else if ((old == 0 || old == 3) && start) nxt = 2;
            else if (old == 2 && why != 0) begin
                nxt = 3;
                m_cause = why;
            end else nxt = old;
            if (nxt == 2 && old != 2) begin
                m_cnt = 0; m_gen = 0; m_cause = 0; m_pv = 1'b0;
            end
            m_state = nxt;
        end
    endtask

    // apply inputs on the falling edge, then compare every output to the model
    task automatic drv(input logic r, input logic rz, input logic s, input logic p,
                       input logic [3:0] rt, input logic [63:0] g);
        bit tick;
        int why;
        bit e_load;
        bit e_mux;
        @(negedge clk);
        reset = r; randomize = rz; start = s; pause = p; rate = rt; grid_in = g;
        #1;
        model_eval(tick, why);
        e_load = !reset && ((m_state == 1) || (tick && why == 0));
        e_mux  = !reset && (m_state == 1);
        chk("state", 64'(state), 64'(m_state));
        chk("seed", seed, m_seed);
        chk("load", 64'(load), 64'(e_load));
        chk("muxseed", 64'(muxseed), 64'(e_mux));
        chk("gen_count", 64'(gen_count), 64'(m_gen));
        chk("halt_cause", 64'(halt_cause), 64'(m_cause));
    endtask

    task automatic adv();
        @(posedge clk);
        model_update();
    endtask

    task automatic cyc(input logic r, input logic rz, input logic s, input logic p,
                       input logic [3:0] rt, input logic [63:0] g);
        drv(r, rz, s, p, rt, g);
        adv();
    endtask

    initial begin
        logic [63:0] lits[3];
        logic [63:0] g;
        logic [3:0]  rt;
        logic        r, rz, s, p;
        int          k;
        lits = '{64'h0123_4567_89AB_CDEF, 64'hD891_A2B3_C4D5_E6F7, 64'hB448_D159_E26A_F37B};

        repeat (2) @(posedge clk);
        model_reset();

        // reset held for five cycles
        for (int i = 0; i < 5; i++) begin
            drv(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 64'h0);
            if (i == 4) begin
                chk("rst_state", 64'(state), 64'd0);
                chk("rst_seed", seed, INIT);
                chk("rst_load", 64'({load, muxseed}), 64'd0);
                chk("rst_gen", 64'(gen_count), 64'd0);
                chk("rst_cause", 64'(halt_cause), 64'd0);
            end
            adv();
        end

        // seeding: randomize for three cycles
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 64'h0);
        for (int i = 0; i < 3; i++) begin
            drv(1'b0, (i < 2) ? 1'b1 : 1'b0, 1'b0, 1'b0, 4'd0, 64'h0);
            chk("seed_state", 64'(state), 64'd1);
            chk("seed_ctl", 64'({load, muxseed}), 64'd3);
            chk("seed_val", seed, lits[i]);
            adv();
        end
        drv(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 64'h0);
        chk("seed_exit", 64'(state), 64'd0);
        adv();

        // blinker at rate 3, then an empty grid at the fourth tick
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd3, BLINK_H);
        g = BLINK_H;
        for (k = 0; k < 16; k++) begin
            drv(1'b0, 1'b0, 1'b0, 1'b0, 4'd3, (k >= 12) ? 64'h0 : g);
            chk("blink_load", 64'(load), 64'((k % 4 == 3) && (k < 12)));
            chk("blink_gen", 64'(gen_count), 64'((k < 12) ? k / 4 : 3));
            adv();
            if (k % 4 == 3) g = (g == BLINK_H) ? BLINK_V : BLINK_H;
        end
        drv(1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 64'h0);
        chk("ext_state", 64'(state), 64'd3);
        chk("ext_cause", 64'(halt_cause), 64'd1);
        adv();

        // restart from HALT onto an empty grid
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 64'h0);
        drv(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 64'h0);
        chk("ext0_load", 64'(load), 64'd0);
        chk("ext0_gen", 64'(gen_count), 64'd0);
        adv();
        drv(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 64'h0);
        chk("ext0_halt", 64'({state, halt_cause}), 64'({2'd3, 2'b01}));
        adv();

        // still-life block at rate 1
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd1, BLOCK);
        for (k = 0; k < 4; k++) begin
            drv(1'b0, 1'b0, 1'b0, 1'b0, 4'd1, BLOCK);
            chk("block_load", 64'(load), 64'(k == 1));
            adv();
        end
        drv(1'b0, 1'b0, 1'b0, 1'b0, 4'd1, BLOCK);
        chk("block_halt", 64'({state, halt_cause}), 64'({2'd3, 2'b10}));
        chk("block_gen", 64'(gen_count), 64'd1);
        adv();

        // pause at rate 0 suppresses steps until released
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, BLINK_H);
        for (k = 0; k < 5; k++) begin
            drv(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, BLINK_H);
            chk("pause_load", 64'(load), 64'd0);
            adv();
        end
        drv(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, BLINK_H);
        chk("unpause_load", 64'({load, muxseed}), 64'd2);
        adv();

        // randomize and start together in HALT; then reset mid-RUN
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, BLINK_V);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 64'h0);
        drv(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 64'h0);
        chk("both_pre", 64'(state), 64'd3);
        adv();
        drv(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 64'h0);
        chk("both_seed", 64'(state), 64'd1);
        adv();
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, BLINK_H);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, BLINK_V);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, BLINK_H);
        drv(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, BLINK_V);
        chk("midrun_gen", 64'(gen_count), 64'd2);
        chk("midrun_load", 64'(load), 64'd0);
        adv();
        drv(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, BLINK_V);
        chk("midrun_rst", 64'({state, gen_count}), 64'd0);
        adv();

        // random stimulus against the reference model
        g = BLINK_H;
        rt = 4'd2;
        for (int n = 0; n < 4000; n++) begin
            r  = ($urandom_range(0, 299) == 0);
            rz = (m_state != 2) && ($urandom_range(0, 24) == 0);
            s  = ($urandom_range(0, 5) == 0);
            p  = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 29) == 0) rt = 4'($urandom_range(0, 15));
            else if ($urandom_range(0, 29) == 0) rt = 4'($urandom_range(0, 3));
            k = int'($urandom_range(0, 9));
            if (k == 0) g = 64'h0;
            else if (k >= 6) g = {$urandom, $urandom};
            cyc(r, rz, s, p, rt, g);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
